// File: rtl/cache_bus_pkg.sv
// ---------------------------------------------------------------------------
// cache_bus_pkg
// Shared definitions for the L2-to-main-memory bus arbiter:
//   - bus_state_t      : burst sequencer state encoding
//   - BUS_WIDTH        : data beat width in bits
//   - LINE_OFFSET_BITS : byte-offset bits of a line at the default beat count
//   - REQ_SNOOP/DEMAND : requester indices used for ownership
//   - line_base()      : clears the in-line byte offset of an address
// ---------------------------------------------------------------------------
package cache_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } bus_state_t;

    localparam int BUS_WIDTH        = 64;
    localparam int DEFAULT_BEATS    = 8;
    // Each beat carries 8 bytes, so a line spans log2(beats) + 3 offset bits.
    localparam int LINE_OFFSET_BITS = $clog2(DEFAULT_BEATS) + 3;

    localparam logic REQ_SNOOP  = 1'b0;
    localparam logic REQ_DEMAND = 1'b1;

    // Return the line base address: the low off_bits bits forced to zero.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int off_bits);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << off_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/bus_prio_select.sv
// ---------------------------------------------------------------------------
// bus_prio_select
// Combinational winner selection between the snoop writeback requester (0)
// and the demand requester (1). Snoop traffic wins ties unless demand has
// already waited through MAX_SNOOP_RUN consecutive snoop grants.
// Ports:
//   i_req0, i_req1 : request lines
//   i_snoop_run    : consecutive snoop grants issued while demand waited
//   o_valid        : at least one request is pending
//   o_winner       : index of the selected requester (REQ_SNOOP/REQ_DEMAND)
// ---------------------------------------------------------------------------
module bus_prio_select
    import cache_bus_pkg::*;
#(
    parameter int MAX_SNOOP_RUN = 3,
    parameter int RUN_W         = 2
) (
    input  logic             i_req0,
    input  logic             i_req1,
    input  logic [RUN_W-1:0] i_snoop_run,
    output logic             o_valid,
    output logic             o_winner
);

    logic w_starved;

    // Priority decode with the demand starvation override.
    always_comb begin
        w_starved = i_req1 && (i_snoop_run >= RUN_W'(MAX_SNOOP_RUN));
        o_valid   = i_req0 | i_req1;
        if (i_req0 && !w_starved) begin
            o_winner = REQ_SNOOP;
        end else if (i_req1) begin
            o_winner = REQ_DEMAND;
        end else begin
            o_winner = REQ_SNOOP;
        end
    end

endmodule

// File: rtl/l2_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// l2_mem_bus_arbiter
// Shares the single L2-to-main-memory port between the snoop writeback path
// (requester 0) and the demand fill/evict path (requester 1). Each grant runs
// one line burst: an address strobe followed by BEATS memory-acknowledged
// data beats. A stalled burst is aborted after TIMEOUT idle cycles.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   req/we/addr/wdata{0,1} : requester command, held until its done pulse
//   gnt{0,1}               : ownership, from grant through the done pulse
//   ack{0,1}, rdata        : per-beat acknowledge and read data
//   done{0,1}, err         : end-of-burst pulse, err flags a timeout abort
//   mem_addrstb, mem_we, mem_addr, mem_wdata : memory-side command/data
//   mem_rdata, mem_stb     : memory read data and beat-complete strobe
// ---------------------------------------------------------------------------
module l2_mem_bus_arbiter
    import cache_bus_pkg::*;
#(
    parameter int BEATS         = 8,
    parameter int MAX_SNOOP_RUN = 3,
    parameter int TIMEOUT       = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [31:0]          addr0,
    input  logic [31:0]          addr1,
    input  logic [BUS_WIDTH-1:0] wdata0,
    input  logic [BUS_WIDTH-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [BUS_WIDTH-1:0] rdata,
    output logic                 done0,
    output logic                 done1,
    output logic                 err,
    output logic                 mem_addrstb,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    input  logic [BUS_WIDTH-1:0] mem_rdata,
    input  logic                 mem_stb
);

    localparam int BEAT_W   = $clog2(BEATS);
    localparam int OFF_BITS = BEAT_W + 3;
    localparam int TMO_W    = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam int RUN_W    = (MAX_SNOOP_RUN > 0) ? $clog2(MAX_SNOOP_RUN + 1) : 1;

    // Registered state
    bus_state_t           r_state;
    logic                 r_owner;
    logic                 r_gnt0;
    logic                 r_gnt1;
    logic                 r_we;
    logic [31:0]          r_line;
    logic [BEAT_W-1:0]    r_beat;
    logic [TMO_W-1:0]     r_tmo;
    logic [RUN_W-1:0]     r_snoop_run;
    logic                 r_abort;
    logic                 r_ack0;
    logic                 r_ack1;
    logic [BUS_WIDTH-1:0] r_rdata;
    logic                 r_done0;
    logic                 r_done1;
    logic                 r_err;
    logic                 r_addrstb;
    logic [31:0]          r_mem_addr;

    // Next-state values
    bus_state_t           w_nxt_state;
    logic                 w_nxt_owner;
    logic                 w_nxt_gnt0;
    logic                 w_nxt_gnt1;
    logic                 w_nxt_we;
    logic [31:0]          w_nxt_line;
    logic [BEAT_W-1:0]    w_nxt_beat;
    logic [TMO_W-1:0]     w_nxt_tmo;
    logic [RUN_W-1:0]     w_nxt_run;
    logic                 w_nxt_abort;
    logic                 w_nxt_ack0;
    logic                 w_nxt_ack1;
    logic [BUS_WIDTH-1:0] w_nxt_rdata;
    logic                 w_nxt_done0;
    logic                 w_nxt_done1;
    logic                 w_nxt_err;
    logic                 w_nxt_addrstb;
    logic [31:0]          w_nxt_mem_addr;

    // Helpers
    logic                 w_sel_valid;
    logic                 w_sel_winner;
    logic [31:0]          w_sel_line;
    logic [BEAT_W-1:0]    w_beat_inc;
    logic [TMO_W-1:0]     w_tmo_inc;
    logic [BUS_WIDTH-1:0] w_mem_wdata;

    bus_prio_select #(
        .MAX_SNOOP_RUN (MAX_SNOOP_RUN),
        .RUN_W         (RUN_W)
    ) u_prio (
        .i_req0      (req0),
        .i_req1      (req1),
        .i_snoop_run (r_snoop_run),
        .o_valid     (w_sel_valid),
        .o_winner    (w_sel_winner)
    );

    // Next-state and next-output decode for the burst sequencer.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_owner    = r_owner;
        w_nxt_gnt0     = r_gnt0;
        w_nxt_gnt1     = r_gnt1;
        w_nxt_we       = r_we;
        w_nxt_line     = r_line;
        w_nxt_beat     = r_beat;
        w_nxt_tmo      = r_tmo;
        w_nxt_run      = r_snoop_run;
        w_nxt_abort    = r_abort;
        w_nxt_ack0     = 1'b0;
        w_nxt_ack1     = 1'b0;
        w_nxt_rdata    = r_rdata;
        w_nxt_done0    = 1'b0;
        w_nxt_done1    = 1'b0;
        w_nxt_err      = 1'b0;
        w_nxt_addrstb  = 1'b0;
        w_nxt_mem_addr = r_mem_addr;

        w_sel_line = line_base((w_sel_winner == REQ_DEMAND) ? addr1 : addr0, OFF_BITS);
        w_beat_inc = r_beat + BEAT_W'(1);
        w_tmo_inc  = (r_tmo == {TMO_W{1'b1}}) ? r_tmo : r_tmo + TMO_W'(1);

        case (r_state)
            ST_IDLE: begin
                if (r_done0 || r_done1) begin
                    // The finishing requester may still hold req during its
                    // done pulse; end the grant and do not arbitrate yet.
                    w_nxt_gnt0     = 1'b0;
                    w_nxt_gnt1     = 1'b0;
                    w_nxt_we       = 1'b0;
                    w_nxt_mem_addr = 32'h0000_0000;
                end else if (w_sel_valid) begin
                    w_nxt_owner    = w_sel_winner;
                    w_nxt_gnt0     = (w_sel_winner == REQ_SNOOP);
                    w_nxt_gnt1     = (w_sel_winner == REQ_DEMAND);
                    w_nxt_we       = (w_sel_winner == REQ_DEMAND) ? we1 : we0;
                    w_nxt_line     = w_sel_line;
                    w_nxt_mem_addr = w_sel_line;
                    w_nxt_beat     = {BEAT_W{1'b0}};
                    w_nxt_tmo      = {TMO_W{1'b0}};
                    w_nxt_abort    = 1'b0;
                    w_nxt_addrstb  = 1'b1;
                    w_nxt_state    = ST_ADDR;
                    // Count snoop grants only while demand is actually waiting.
                    if (!req1) begin
                        w_nxt_run = {RUN_W{1'b0}};
                    end else if (w_sel_winner == REQ_DEMAND) begin
                        w_nxt_run = {RUN_W{1'b0}};
                    end else if (r_snoop_run < RUN_W'(MAX_SNOOP_RUN)) begin
                        w_nxt_run = r_snoop_run + RUN_W'(1);
                    end else begin
                        w_nxt_run = r_snoop_run;
                    end
                end else begin
                    w_nxt_gnt0     = 1'b0;
                    w_nxt_gnt1     = 1'b0;
                    w_nxt_we       = 1'b0;
                    w_nxt_mem_addr = 32'h0000_0000;
                    w_nxt_run      = {RUN_W{1'b0}};
                end
            end
            ST_ADDR: begin
                // Any mem_stb in this cycle is deliberately ignored.
                w_nxt_tmo   = {TMO_W{1'b0}};
                w_nxt_state = ST_XFER;
            end
            ST_XFER: begin
                if (mem_stb) begin
                    w_nxt_ack0     = (r_owner == REQ_SNOOP);
                    w_nxt_ack1     = (r_owner == REQ_DEMAND);
                    w_nxt_tmo      = {TMO_W{1'b0}};
                    w_nxt_beat     = w_beat_inc;
                    w_nxt_mem_addr = r_line | 32'({w_beat_inc, 3'b000});
                    if (!r_we) begin
                        w_nxt_rdata = mem_rdata;
                    end else begin
                        w_nxt_rdata = r_rdata;
                    end
                    if (r_beat == BEAT_W'(BEATS - 1)) begin
                        w_nxt_state = ST_DONE;
                    end else begin
                        w_nxt_state = ST_XFER;
                    end
                end else if (r_tmo >= TMO_W'(TIMEOUT - 1)) begin
                    // This idle cycle brings the count to TIMEOUT: abort.
                    w_nxt_tmo   = w_tmo_inc;
                    w_nxt_abort = 1'b1;
                    w_nxt_state = ST_DONE;
                end else begin
                    w_nxt_tmo   = w_tmo_inc;
                    w_nxt_state = ST_XFER;
                end
            end
            ST_DONE: begin
                w_nxt_done0 = (r_owner == REQ_SNOOP);
                w_nxt_done1 = (r_owner == REQ_DEMAND);
                w_nxt_err   = r_abort;
                w_nxt_abort = 1'b0;
                w_nxt_beat  = {BEAT_W{1'b0}};
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_gnt0     = 1'b0;
                w_nxt_gnt1     = 1'b0;
                w_nxt_we       = 1'b0;
                w_nxt_mem_addr = 32'h0000_0000;
                w_nxt_state    = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner     <= REQ_SNOOP;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_we        <= 1'b0;
            r_line      <= 32'h0000_0000;
            r_beat      <= {BEAT_W{1'b0}};
            r_tmo       <= {TMO_W{1'b0}};
            r_snoop_run <= {RUN_W{1'b0}};
            r_abort     <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rdata     <= {BUS_WIDTH{1'b0}};
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_err       <= 1'b0;
            r_addrstb   <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
        end else begin
            r_owner     <= w_nxt_owner;
            r_gnt0      <= w_nxt_gnt0;
            r_gnt1      <= w_nxt_gnt1;
            r_we        <= w_nxt_we;
            r_line      <= w_nxt_line;
            r_beat      <= w_nxt_beat;
            r_tmo       <= w_nxt_tmo;
            r_snoop_run <= w_nxt_run;
            r_abort     <= w_nxt_abort;
            r_ack0      <= w_nxt_ack0;
            r_ack1      <= w_nxt_ack1;
            r_rdata     <= w_nxt_rdata;
            r_done0     <= w_nxt_done0;
            r_done1     <= w_nxt_done1;
            r_err       <= w_nxt_err;
            r_addrstb   <= w_nxt_addrstb;
            r_mem_addr  <= w_nxt_mem_addr;
        end
    end

    // Write data follows the current owner; zero while nobody holds the bus.
    always_comb begin
        if (r_gnt0) begin
            w_mem_wdata = wdata0;
        end else if (r_gnt1) begin
            w_mem_wdata = wdata1;
        end else begin
            w_mem_wdata = {BUS_WIDTH{1'b0}};
        end
    end

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign rdata       = r_rdata;
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign err         = r_err;
    assign mem_addrstb = r_addrstb;
    assign mem_we      = r_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = w_mem_wdata;

endmodule

// File: tb/tb_l2_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_mem_bus_arbiter
// Directed bench for l2_mem_bus_arbiter: reset state, single read burst,
// snoop priority, demand starvation guard, timeout abort and reset mid-burst.
// ---------------------------------------------------------------------------
module tb_l2_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1;
    logic [63:0] wdata0, wdata1;
    logic        gnt0, gnt1, ack0, ack1;
    logic [63:0] rdata;
    logic        done0, done1, err;
    logic        mem_addrstb, mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_stb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l2_mem_bus_arbiter #(
        .BEATS         (8),
        .MAX_SNOOP_RUN (3),
        .TIMEOUT       (255)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .ack0        (ack0),
        .ack1        (ack1),
        .rdata       (rdata),
        .done0       (done0),
        .done1       (done1),
        .err         (err),
        .mem_addrstb (mem_addrstb),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_stb     (mem_stb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full burst starting at the IDLE sampling edge; returns in the
    // done-pulse cycle. Optionally drives mem_stb during ADDR (must be ignored).
    task automatic do_burst(input string tag, input logic owner, input logic [31:0] base,
                            input logic we, input logic stb_in_addr);
        step();
        chk({tag, "_addrstb"}, 64'(mem_addrstb), 64'(1'b1));
        chk({tag, "_gnt"}, 64'({gnt1, gnt0}), owner ? 64'(2'b10) : 64'(2'b01));
        chk({tag, "_base"}, 64'(mem_addr), 64'(base));
        chk({tag, "_we"}, 64'(mem_we), 64'(we));
        mem_stb = stb_in_addr;
        step();
        chk({tag, "_noack_addr"}, 64'({ack1, ack0}), 64'(2'b00));
        for (int b = 0; b < 8; b++) begin
            mem_stb   = 1'b1;
            mem_rdata = 64'h5A5A_0000_0000_0000 | 64'(b);
            step();
            chk({tag, "_ack"}, 64'({ack1, ack0}), owner ? 64'(2'b10) : 64'(2'b01));
        end
        mem_stb = 1'b0;
        step();
        chk({tag, "_done"}, 64'({done1, done0}), owner ? 64'(2'b10) : 64'(2'b01));
        chk({tag, "_err"}, 64'(err), 64'(1'b0));
    endtask

    initial begin
        int  k;
        logic seen;

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 64'h0; wdata1 = 64'h0;
        mem_rdata = 64'h0; mem_stb = 1'b0;

        // ---------------- reset state ----------------
        step(); step(); step();
        chk("rst_gnt",   64'({gnt1, gnt0}), 64'(2'b00));
        chk("rst_ack",   64'({ack1, ack0}), 64'(2'b00));
        chk("rst_done",  64'({done1, done0, err}), 64'(3'b000));
        chk("rst_stb",   64'({mem_addrstb, mem_we}), 64'(2'b00));
        chk("rst_addr",  64'(mem_addr), 64'h0);
        chk("rst_wdata", mem_wdata, 64'h0);
        chk("rst_rdata", rdata, 64'h0);
        rst_n = 1'b1;
        step();

        // ---------------- single read ----------------
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_1234;
        step();
        chk("rd_gnt",     64'({gnt1, gnt0}), 64'(2'b10));
        chk("rd_addrstb", 64'(mem_addrstb), 64'(1'b1));
        chk("rd_addr0",   64'(mem_addr), 64'h1200);
        chk("rd_we",      64'(mem_we), 64'(1'b0));
        step();
        chk("rd_addrstb_pulse", 64'(mem_addrstb), 64'(1'b0));
        for (int b = 0; b < 8; b++) begin
            mem_stb   = 1'b1;
            mem_rdata = 64'hC0DE_0000_0000_0000 | 64'(b * 17);
            step();
            chk("rd_ack",   64'(ack1), 64'(1'b1));
            chk("rd_rdata", rdata, 64'hC0DE_0000_0000_0000 | 64'(b * 17));
            if (b < 7) begin
                chk("rd_addr_step", 64'(mem_addr), 64'(32'h1200 + 32'(8 * (b + 1))));
            end
        end
        mem_stb = 1'b0;
        chk("rd_done_early", 64'(done1), 64'(1'b0));
        step();
        chk("rd_done", 64'(done1), 64'(1'b1));
        chk("rd_ack_clear", 64'(ack1), 64'(1'b0));
        chk("rd_err", 64'(err), 64'(1'b0));
        req1 = 1'b0;
        step();
        chk("rd_after", 64'({gnt1, done1}), 64'(2'b00));

        // ---------------- priority ----------------
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8000_0047; wdata0 = 64'hAAAA_0000_1111_0000;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_2000; wdata1 = 64'hBBBB_0000_2222_0000;
        do_burst("pri0", 1'b0, 32'h8000_0040, 1'b1, 1'b1);
        chk("pri0_wdata", mem_wdata, 64'hAAAA_0000_1111_0000);
        req0 = 1'b0;
        step();
        chk("pri_dead_gnt",   64'({gnt1, gnt0}), 64'(2'b00));
        chk("pri_dead_wdata", mem_wdata, 64'h0);
        do_burst("pri1", 1'b1, 32'h0000_2000, 1'b1, 1'b0);
        chk("pri1_wdata", mem_wdata, 64'hBBBB_0000_2222_0000);
        req1 = 1'b0;
        step();

        // ---------------- starvation guard ----------------
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_0400;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0800;
        do_burst("stv_a", 1'b0, 32'h0000_0400, 1'b1, 1'b0);
        step();
        do_burst("stv_b", 1'b0, 32'h0000_0400, 1'b1, 1'b0);
        step();
        do_burst("stv_c", 1'b0, 32'h0000_0400, 1'b1, 1'b0);
        step();
        do_burst("stv_d", 1'b1, 32'h0000_0800, 1'b0, 1'b0);
        req1 = 1'b0;
        step();
        do_burst("stv_e", 1'b0, 32'h0000_0400, 1'b1, 1'b0);
        req0 = 1'b0;
        step();

        // ---------------- timeout ----------------
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0040;
        step();
        chk("tmo_gnt", 64'({gnt1, gnt0}), 64'(2'b10));
        step();
        for (int b = 0; b < 3; b++) begin
            mem_stb = 1'b1;
            step();
            chk("tmo_ack", 64'(ack1), 64'(1'b1));
        end
        mem_stb = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 400) begin
            step();
            k++;
            if (done1) begin
                seen = 1'b1;
            end
        end
        chk("tmo_seen",   64'(seen), 64'(1'b1));
        chk("tmo_cycles", 64'(k), 64'd256);
        chk("tmo_err",    64'(err), 64'(1'b1));
        req1 = 1'b0;
        step();
        chk("tmo_err_pulse", 64'({err, done1}), 64'(2'b00));
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0300;
        do_burst("tmo_next", 1'b0, 32'h0000_0300, 1'b0, 1'b0);
        req0 = 1'b0;
        step();

        // ---------------- reset mid-burst ----------------
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_0100; wdata0 = 64'h1234_5678_9ABC_DEF0;
        step();
        step();
        for (int b = 0; b < 4; b++) begin
            mem_stb = 1'b1;
            step();
        end
        mem_stb = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mrst_gnt",   64'({gnt1, gnt0}), 64'(2'b00));
        chk("mrst_ack",   64'({ack1, ack0}), 64'(2'b00));
        chk("mrst_done",  64'({done1, done0, err}), 64'(3'b000));
        chk("mrst_stb",   64'({mem_addrstb, mem_we}), 64'(2'b00));
        chk("mrst_addr",  64'(mem_addr), 64'h0);
        chk("mrst_wdata", mem_wdata, 64'h0);
        chk("mrst_rdata", rdata, 64'h0);
        rst_n = 1'b1;
        do_burst("mrst_new", 1'b0, 32'h0000_0100, 1'b1, 1'b0);
        req0 = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_mem_bus_arbiter.md
# l2_mem_bus_arbiter

Sequences and shares the single L2-to-main-memory port between two L2-side requesters: the snoop writeback path (requester 0, MESI Modified lines flushed on a snoop hit) and the demand path (requester 1, line fills and victim evictions). It sits between the L2 cache controller and main memory. Each grant runs one complete line burst: an address strobe, then `BEATS` data beats acknowledged by memory. Snoop writebacks take priority, backed by a starvation guard for demand traffic, and a timeout aborts a stalled burst.

## Interface
- `BEATS`, 8: 64-bit beats per line transfer; must be a power of two, ≥2.
- `MAX_SNOOP_RUN`, 3: consecutive snoop grants allowed while demand waits.
- `TIMEOUT`, 255: idle cycles allowed between beats before abort.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  one clock; reset is synchronous and active-low.
- `req0`, `req1`  in  1  request; must be held until the matching `done`.
- `we0`, `we1`  in  1  1 = write to memory, 0 = read from memory.
- `addr0`, `addr1`  in  32  line base address; low `log2(BEATS)+3` bits are ignored.
- `wdata0`, `wdata1`  in  64  write beat data; the requester advances it on `ack`.
- `gnt0`, `gnt1`  out  1  high from the grant until `done`; one-hot or zero.
- `ack0`, `ack1`  out  1  one-cycle pulse per completed beat.
- `rdata`  out  64  read beat data, valid with `ack`.
- `done0`, `done1`  out  1  one-cycle pulse at the end of the burst.
- `err`  out  1  one-cycle pulse on timeout abort, coincident with `done`.
- `mem_addrstb`  out  1  one-cycle address strobe.
- `mem_we`  out  1  write enable for the current burst.
- `mem_addr`  out  32  line base with low bits zeroed, plus `8*beat`.
- `mem_wdata`  out  64  mux of the granted requester's `wdata`.
- `mem_rdata`  in  64  memory read data.
- `mem_stb`  in  1  memory beat-complete strobe.

## Operation
- States: IDLE, ADDR, XFER, DONE.
- **IDLE.** If any request is high, select the owner, register `gnt`, `we` and the line address, then go to ADDR.
- **Selection.** Requester 0 wins when both request. When `snoop_run == MAX_SNOOP_RUN` and `req1` is high, requester 1 wins instead.
- **`snoop_run` counter.**
  - +1 on a requester-0 grant while `req1` is high, saturating.
  - Cleared on any requester-1 grant.
  - Cleared whenever `req1` is low at selection time.
- **ADDR.** Pulse `mem_addrstb` with `mem_addr` = line base and beat = 0, then go to XFER.
- **XFER.**
  - Each `mem_stb` pulses `ack` of the owner and increments the beat counter.
  - `mem_addr` tracks the beat.
  - On the final beat (`beat == BEATS-1` with `mem_stb`), go to DONE.
  - Each `mem_stb` resets the timeout counter; otherwise it increments. Reaching `TIMEOUT` goes to DONE with `err` set.
- **DONE.** Pulse the owner's `done` (and `err` if aborted), drop `gnt`, return to IDLE.
- **Request handling during a burst.** A request dropped mid-burst is ignored and the burst completes. Requests are sampled only in IDLE.
- **`rdata`.** Equals `mem_rdata`, registered on `mem_stb` during a read burst.
- **`mem_wdata`.** Combinational from the owner. Zero when there is no owner.
- **Reset values.** All outputs 0, state IDLE, counters 0.

## Timing
- Request-to-`mem_addrstb` latency: 2 cycles (IDLE sample, then ADDR).
- `mem_stb` is never expected in the ADDR cycle. A `mem_stb` seen in ADDR is ignored.
- `ack` is registered: it asserts the cycle after `mem_stb`.
- `done` asserts 1 cycle after the final `ack`.
- Minimum burst, request to `done`: `BEATS + 4` cycles.
- Back-to-back: after `done`, IDLE re-arbitrates on the next cycle, so there is 1 dead cycle between bursts.
- Reset mid-burst: all outputs cleared at the next edge; the burst is abandoned without `done`.
- Beat counter width is `log2(BEATS)`; it wraps to 0 on completion.
- Timeout counter is 8 bits minimum (sized by `TIMEOUT`) and saturates.

## Structure
- Shared package `cache_bus_pkg`:
  - state encoding
  - `LINE_OFFSET_BITS`
  - `BUS_WIDTH = 64`
  - requester indices `REQ_SNOOP = 0`, `REQ_DEMAND = 1`
- Sub-module `bus_prio_select`: combinational winner selection from `req0`, `req1` and `snoop_run`. Everything else lives in one module.

## Test plan
- **Single read.** `req1=1`, `we1=0`, `addr1=0x0000_1234` → `mem_addrstb` 2 cycles later with `mem_addr=0x1200`. 8 `mem_stb` beats each give `ack1` with `rdata` echoed, and `mem_addr` steps by 8. `done1` follows the last `ack1`.
- **Priority.** `req0` and `req1` raised together, writes → `gnt0` first. `gnt1` follows after `done0` plus 1 dead cycle. `mem_wdata` follows `wdata0`, then `wdata1`.
- **Starvation.** `req0` held continuously with `req1` high → exactly 3 requester-0 bursts, then a requester-1 burst, then requester 0 again.
- **Timeout.** Memory stops after 3 beats → `done` and `err` pulse together after 255 idle cycles. Next arbitration proceeds normally.
- **Reset mid-burst.** Assert `rst_n=0` during XFER beat 4 → next cycle all outputs are 0, no `done`, state IDLE. A new request completes cleanly.
